// File: rtl/map_fetch_if.sv
// Pixel, scroll-control and map-memory signals of the map fetch block.
// The slave side is the fetch block; the master side is timing generator plus map memory.
interface map_fetch_if;
    logic [11:0] pixel_row;
    logic [11:0] pixel_column;
    logic        video_on;
    logic        frame_start;
    logic [11:0] scroll_x;
    logic        scroll_load;
    logic [14:0] map_addr;
    logic [1:0]  map_data;
    logic [1:0]  map_value;
    logic        out_of_map;
    logic [11:0] world_row;
    logic [11:0] world_column;
    logic        pix_valid;
    logic        scroll_pending;

    modport master (
        output pixel_row, pixel_column, video_on, frame_start, scroll_x, scroll_load, map_data,
        input  map_addr, map_value, out_of_map, world_row, world_column, pix_valid, scroll_pending
    );

    modport slave (
        input  pixel_row, pixel_column, video_on, frame_start, scroll_x, scroll_load, map_data,
        output map_addr, map_value, out_of_map, world_row, world_column, pix_valid, scroll_pending
    );
endinterface

// File: rtl/map_fetch.sv
// Scrolling tile-map fetch: converts display coordinates to map-space, issues the
// map memory read and realigns pixel attributes with the returned cell value.
module map_fetch #(
    parameter int unsigned CELL_SHIFT  = 3,
    parameter int unsigned MAP_COLS    = 256,
    parameter int unsigned MAP_ROWS    = 96,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    map_fetch_if.slave bus
);
    localparam int unsigned WX_SPAN  = MAP_COLS << CELL_SHIFT;
    localparam int unsigned WY_LIMIT = MAP_ROWS << CELL_SHIFT;
    localparam logic [11:0] WX_MASK  = (WX_SPAN >= 4096) ? 12'hFFF : 12'(WX_SPAN - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] pending_q, pending_d;
    logic [11:0] active_q, active_d;

    logic [11:0] wx_q, wx_d;
    logic [11:0] wy_q, wy_d;
    logic        oom_q, oom_d;
    logic        von_q, von_d;
    logic [14:0] map_addr_q, map_addr_d;
    logic [11:0] col_sum;

    logic [11:0] dl_wx_q  [MEM_LATENCY];
    logic [11:0] dl_wx_d  [MEM_LATENCY];
    logic [11:0] dl_wy_q  [MEM_LATENCY];
    logic [11:0] dl_wy_d  [MEM_LATENCY];
    logic        dl_oom_q [MEM_LATENCY];
    logic        dl_oom_d [MEM_LATENCY];
    logic        dl_von_q [MEM_LATENCY];
    logic        dl_von_d [MEM_LATENCY];

    // A load in the same cycle as the transfer becomes the next pending value.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        active_d  = active_q;
        case (state_q)
            IDLE: begin
                if (bus.scroll_load) begin
                    pending_d = bus.scroll_x;
                    state_d   = PENDING;
                end
            end
            PENDING: begin
                if (bus.frame_start) begin
                    active_d = pending_q;
                    state_d  = IDLE;
                end
                if (bus.scroll_load) begin
                    pending_d = bus.scroll_x;
                    state_d   = PENDING;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        col_sum    = bus.pixel_column + active_q;
        wx_d       = col_sum & WX_MASK;
        wy_d       = bus.pixel_row;
        oom_d      = !bus.video_on || (32'(bus.pixel_row) >= WY_LIMIT);
        von_d      = bus.video_on;
        map_addr_d = oom_d ? map_addr_q
                           : {7'(wy_d >> CELL_SHIFT), 8'(wx_d >> CELL_SHIFT)};
    end

    // Delay line matches the memory read latency so attributes meet map_data.
    always_comb begin
        dl_wx_d[0]  = wx_q;
        dl_wy_d[0]  = wy_q;
        dl_oom_d[0] = oom_q;
        dl_von_d[0] = von_q;
        for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
            dl_wx_d[i]  = dl_wx_q[i-1];
            dl_wy_d[i]  = dl_wy_q[i-1];
            dl_oom_d[i] = dl_oom_q[i-1];
            dl_von_d[i] = dl_von_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            active_q   <= '0;
            wx_q       <= '0;
            wy_q       <= '0;
            oom_q      <= 1'b1;
            von_q      <= 1'b0;
            map_addr_q <= '0;
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                dl_wx_q[i]  <= '0;
                dl_wy_q[i]  <= '0;
                dl_oom_q[i] <= 1'b1;
                dl_von_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            active_q   <= active_d;
            wx_q       <= wx_d;
            wy_q       <= wy_d;
            oom_q      <= oom_d;
            von_q      <= von_d;
            map_addr_q <= map_addr_d;
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                dl_wx_q[i]  <= dl_wx_d[i];
                dl_wy_q[i]  <= dl_wy_d[i];
                dl_oom_q[i] <= dl_oom_d[i];
                dl_von_q[i] <= dl_von_d[i];
            end
        end
    end

    assign bus.map_addr       = map_addr_q;
    assign bus.map_value      = dl_oom_q[MEM_LATENCY-1] ? 2'b00 : bus.map_data;
    assign bus.out_of_map     = dl_oom_q[MEM_LATENCY-1];
    assign bus.world_row      = dl_wy_q[MEM_LATENCY-1];
    assign bus.world_column   = dl_wx_q[MEM_LATENCY-1];
    assign bus.pix_valid      = dl_von_q[MEM_LATENCY-1];
    assign bus.scroll_pending = (state_q == PENDING);
endmodule
